// File: rtl/count_seq_pkg.sv
// ============================================================================
// Module   : count_seq_pkg
// Brief    : Shared state encoding and default width for the count sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_seq_pkg;

  localparam int c_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/incr_unit.sv
// ============================================================================
// Module   : incr_unit
// Brief    : Combinational WIDTH-bit +1 incrementer, wraps modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module incr_unit
  import count_seq_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_sum
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Carry out is intentionally dropped so the all-ones value rolls to zero.
  assign o_sum = i_val + c_ONE;

endmodule

`default_nettype wire

// File: rtl/count_sequencer.sv
// ============================================================================
// Module   : count_sequencer
// Brief    : Start/stop/load controller turning a +1 incrementer into a
//            programmable-limit up-counter with one-shot or auto-reload modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_lim;
  logic             r_ar;
  logic             r_busy;
  logic             r_tc;
  logic             r_done;
  logic [WIDTH-1:0] w_inc;

  incr_unit #(
    .WIDTH (WIDTH)
  ) u_incr (
    .i_val (r_cnt),
    .o_sum (w_inc)
  );

  // busy/tc/done are computed alongside the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_lim   <= '0;
      r_ar    <= 1'b0;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (load) begin
            r_cnt <= load_val;
          end else if (start) begin
            r_lim   <= limit;
            r_ar    <= auto_reload;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (load) begin
            r_cnt <= load_val;
          end else if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (en) begin
            if (r_cnt != r_lim) begin
              r_cnt <= w_inc;
            end else begin
              r_tc <= 1'b1;
              if (r_ar) begin
                r_cnt <= '0;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_out = r_cnt;
  assign busy    = r_busy;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// ============================================================================
// Module   : tb_count_sequencer
// Brief    : Directed-vector scoreboard bench for count_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] limit = 4'h0;
  logic       auto_reload = 1'b0;
  logic [3:0] cnt_out;
  logic       busy;
  logic       tc;
  logic       done;

  typedef struct {
    logic [3:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   step_id = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  count_sequencer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .limit       (limit),
    .auto_reload (auto_reload),
    .cnt_out     (cnt_out),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
  endtask

  // Monitor: one expected record per clock edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("cnt_out", e.id, cnt_out, e.cnt);
      chk("busy", e.id, {3'b0, busy}, {3'b0, e.busy});
      chk("tc", e.id, {3'b0, tc}, {3'b0, e.tc});
      chk("done", e.id, {3'b0, done}, {3'b0, e.done});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic st, input logic sp, input logic e,
                      input logic ld, input logic [3:0] lv, input logic [3:0] lim,
                      input logic ar, input logic [3:0] x_cnt, input logic x_busy,
                      input logic x_tc, input logic x_done);
    exp_t x;
    @(negedge clk);
    rst = r; start = st; stop = sp; en = e; load = ld;
    load_val = lv; limit = lim; auto_reload = ar;
    step_id++;
    x.cnt = x_cnt; x.busy = x_busy; x.tc = x_tc; x.done = x_done; x.id = step_id;
    sb_q.push_back(x);
  endtask

  initial begin
    //     rst st sp en ld lv     lim    ar   cnt    bsy tc dn
    // Reset then idle
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 0,   4'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 0,   4'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0);

    // One-shot to limit 3
    step(0, 1, 0, 1, 0, 4'h0, 4'h3, 0,   4'h0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h3, 0,   4'h1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h3, 0,   4'h2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h3, 0,   4'h3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h3, 0,   4'h3, 0, 1, 1);
    step(0, 0, 0, 1, 0, 4'h0, 4'h3, 0,   4'h3, 0, 0, 0);

    // Auto-reload limit 2 with an enable gap; limit changes mid-run are ignored
    step(0, 0, 0, 0, 1, 4'h0, 4'h2, 1,   4'h0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 4'h0, 4'h2, 1,   4'h0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 4'h7, 0,   4'h1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 4'h7, 0,   4'h1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h7, 0,   4'h1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 4'h0, 4'h7, 0,   4'h1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 4'h0, 4'h7, 0,   4'h1, 0, 0, 0);

    // Wrap-around E,F,0,1; start/load in DONE are ignored
    step(0, 0, 0, 0, 1, 4'hE, 4'h1, 0,   4'hE, 0, 0, 0);
    step(0, 1, 0, 1, 0, 4'h0, 4'h1, 0,   4'hE, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h1, 0,   4'hF, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h1, 0,   4'h0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h1, 0,   4'h1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h1, 0,   4'h1, 0, 1, 1);
    step(0, 1, 0, 1, 1, 4'h5, 4'h1, 0,   4'h1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h1, 0,   4'h1, 0, 0, 0);

    // Precedence: load beats stop in RUN, then stop alone returns to IDLE
    step(0, 0, 0, 0, 1, 4'h5, 4'hC, 0,   4'h5, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 4'hC, 0,   4'h5, 1, 0, 0);
    step(0, 0, 1, 1, 1, 4'h9, 4'hC, 0,   4'h9, 1, 0, 0);
    step(0, 0, 1, 1, 0, 4'h0, 4'hC, 0,   4'h9, 0, 0, 0);

    // Limit 0 from count 0: terminal on first enabled cycle
    step(0, 0, 0, 0, 1, 4'h0, 4'h0, 0,   4'h0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 4'h0, 4'h0, 0,   4'h0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'h0, 0,   4'h0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 4'h0, 4'h0, 0,   4'h0, 0, 0, 0);

    // Reset mid-run at count 7
    step(0, 0, 0, 0, 1, 4'h7, 4'hA, 1,   4'h7, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 4'hA, 1,   4'h7, 1, 0, 0);
    step(1, 0, 0, 1, 0, 4'h0, 4'hA, 1,   4'h0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'h0, 4'hA, 1,   4'h0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected records left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
